bfxp_arbiter: RTL
=================

Name: bfxp_arbiter

Overview:
Round-robin arbiter and sequencer that shares one simplebfxp bit-field extract/place unit between NREQ requesters. It accepts operand sets over per-requester valid/ready handshakes and issues at most one operation per clock to the shared unit. It tracks in-flight operations through the unit's fixed latency and returns each result to its originator through a per-requester valid/ready response slot.

Parameters:
NREQ, 4, number of requesters (2..8)
LATENCY, 1, cycles from issue cycle to the cycle in which bfxp_rd is valid (simplebfxp = 1)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
req_valid  input  NREQ  requester i has an operation
req_ready  output  NREQ  operation of requester i accepted this cycle
req_rs1  input  NREQ*32  source word, requester i at [32*i+31:32*i]
req_start  input  NREQ*5  field start bit, requester i at [5*i+4:5*i]
req_len  input  NREQ*5  field length, packed like req_start
req_dest  input  NREQ*5  placement bit, packed like req_start
rsp_valid  output  NREQ  result held for requester i
rsp_ready  input  NREQ  requester i takes result
rsp_rd  output  NREQ*32  result word for requester i
bfxp_rs1  output  32  to shared unit rs1
bfxp_start  output  5  to shared unit start
bfxp_len  output  5  to shared unit len
bfxp_dest  output  5  to shared unit dest
bfxp_rd  input  32  from shared unit rd
busy  output  1  any op in flight or any rsp_valid set

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. During reset and on the first cycle after it: rsp_valid=0, rsp_rd=0, req_ready=0, busy=0, in-flight pipeline cleared, RR pointer=0 (requester 0 highest priority).
- Pending flag: pend[i] is set from grant until its result is drained. Eligibility: elig[i] = req_valid[i] & ~pend[i].
- Grant: combinational round-robin over elig. The search starts at ptr and wraps NREQ-1 -> 0. At most one grant per cycle.
- Issue: req_ready[g]=1 for the granted g only, in the same cycle. Acceptance is req_valid & req_ready. bfxp_rs1/start/len/dest = operands of g that cycle; all zero when no grant.
- Pointer update: on a grant, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- Pipeline: a shift register of LATENCY stages holds {valid, tag[clog2(NREQ)]}. The issue cycle enters stage 0. When the last stage is valid in cycle T+LATENCY, the controller captures bfxp_rd into rsp_rd[tag] at the end of that cycle and sets rsp_valid[tag]. bfxp_rd is ignored when the last stage is invalid.
- Drain: rsp_valid[i] & rsp_ready[i] clears rsp_valid[i] and pend[i] at the clock edge. rsp_rd[i] holds its last value afterwards.
- Latency: accept in cycle T -> rsp_valid high from cycle T+LATENCY+1.
- Per-requester throughput: one op per LATENCY+2 cycles at best, because requester i is re-eligible only in the cycle after its drain. Aggregate throughput: one op per cycle when NREQ >= LATENCY+2 and all requesters drain immediately.
- Back-pressure: a result is never overwritten, because a requester with pend set cannot issue. A stalled rsp_ready[i] blocks only requester i.
- Simultaneous events: capture for tag j and drain for k != j in the same cycle are both honoured. Grant and drain of the same requester in the same cycle cannot occur.
- Operands are not interpreted. len/start/dest pass through bit-exact.
- busy = |pend.
- Reset mid-operation: in-flight ops are discarded and any bfxp_rd arriving after reset is ignored. rsp_valid clears without a handshake.

Test Plan:
- Single op: requester 0 drives rs1=0x12345678 start=4 len=8 dest=16 -> req_ready[0]=1 in the same cycle, bfxp_* carry those values. rsp_valid[0] rises 2 cycles later with rsp_rd[0] equal to the simplebfxp reference model (0x00670000). busy=1 from the accept edge until the drain.
- Contention: all 4 requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0,... The shared unit issues every cycle, and each requester's results come back in order matching the model.
- Back-pressure: requester 2 holds rsp_ready=0 for 10 cycles -> rsp_rd[2] stable, req_ready[2]=0 throughout, and requesters 0,1,3 keep issuing. After release, requester 2 is granted again in the cycle after its drain.
- Fairness: requesters 1 and 3 permanently valid, others idle -> alternating grants 1,3,1,3 with no starvation, pointer wrapping correctly.
- Reset mid-flight: assert reset in the cycle after issuing for requester 1 -> no rsp_valid after reset, the late bfxp_rd is ignored, and the next grant goes to requester 0 when several requesters are valid.
- Randomised 1000 ops over random requesters and random rsp_ready -> every rsp_rd matches the model, with no lost or duplicated results.

Source files
------------

// File: rtl/bfxp_arbiter.sv
// bfxp_arbiter: round-robin front end that shares one bit-field
// extract/place unit between NREQ requesters. It issues at most one
// operation per cycle, follows each operation through the unit's fixed
// latency, and parks every result in a per-requester response slot until
// that requester takes it.
module bfxp_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_rs1,
   input  logic [NREQ*5-1:0]    req_start,
   input  logic [NREQ*5-1:0]    req_len,
   input  logic [NREQ*5-1:0]    req_dest,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [NREQ*32-1:0]   rsp_rd,
   output logic [31:0]          bfxp_rs1,
   output logic [4:0]           bfxp_start,
   output logic [4:0]           bfxp_len,
   output logic [4:0]           bfxp_dest,
   input  logic [31:0]          bfxp_rd,
   output logic                 busy
);

   localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // pend[i]: requester i has an operation in the unit or a result waiting
   logic [NREQ-1:0] pend;
   // Round-robin pointer: index of the highest-priority requester
   logic [TW-1:0]   ptr;
   // Low for exactly one cycle after reset so no grant happens in that cycle
   logic            armed;

   // In-flight tracking through the shared unit's latency
   logic            pipe_v   [LATENCY];
   logic [TW-1:0]   pipe_tag [LATENCY];

   logic [NREQ-1:0] elig;
   logic            gnt_any;
   logic [TW-1:0]   gnt_idx;

   // Round-robin grant: two passes (indices at/above ptr, then below ptr)
   // give the same order as a wrapping search without modulo arithmetic.
   always_comb begin
      elig    = req_valid & ~pend;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (armed && !reset) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_any && elig[k] && (k >= 32'(ptr))) begin
               gnt_any = 1'b1;
               gnt_idx = TW'(k);
            end
         end
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_any && elig[k] && (k < 32'(ptr))) begin
               gnt_any = 1'b1;
               gnt_idx = TW'(k);
            end
         end
      end
   end

   // Handshake back to the winner and operand mux toward the shared unit
   always_comb begin
      req_ready  = '0;
      bfxp_rs1   = '0;
      bfxp_start = '0;
      bfxp_len   = '0;
      bfxp_dest  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt_any && (gnt_idx == TW'(k))) begin
            req_ready[k] = 1'b1;
            bfxp_rs1     = req_rs1[32*k +: 32];
            bfxp_start   = req_start[5*k +: 5];
            bfxp_len     = req_len[5*k +: 5];
            bfxp_dest    = req_dest[5*k +: 5];
         end
      end
   end

   // Post-reset arming flag
   always_ff @(posedge clock) begin
      if (reset) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   // Pointer advances past the winner; holds when nothing is granted
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (gnt_any) begin
         if (gnt_idx == TW'(NREQ - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= gnt_idx + TW'(1);
         end
      end
   end

   // Shift register carrying {valid, tag} alongside the unit's latency
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned s = 0; s < LATENCY; s++) begin
            pipe_v[s]   <= 1'b0;
            pipe_tag[s] <= '0;
         end
      end else begin
         pipe_v[0]   <= gnt_any;
         pipe_tag[0] <= gnt_idx;
         for (int unsigned s = 1; s < LATENCY; s++) begin
            pipe_v[s]   <= pipe_v[s-1];
            pipe_tag[s] <= pipe_tag[s-1];
         end
      end
   end

   // Response slots: capture returning results, drain on handshake,
   // and track the pending flag from grant until drain.
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_rd    <= '0;
         pend      <= '0;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (rsp_valid[k] && rsp_ready[k]) begin
               rsp_valid[k] <= 1'b0;
               pend[k]      <= 1'b0;
            end
            if (pipe_v[LATENCY-1] && (pipe_tag[LATENCY-1] == TW'(k))) begin
               rsp_valid[k]        <= 1'b1;
               rsp_rd[32*k +: 32]  <= bfxp_rd;
            end
            if (gnt_any && (gnt_idx == TW'(k))) begin
               pend[k] <= 1'b1;
            end
         end
      end
   end

   assign busy = |pend;

endmodule
